// File: rtl/clock_pkg.sv
// Shared types and constants for the time/alarm setting sequencer.
// Imported by the controller and by anything that decodes its state.
package clock_pkg;

  typedef enum logic [2:0] {
    NORMAL,
    T_HOUR,
    T_MIN,
    A_HOUR,
    A_MIN
  } state_e;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  // digit_blank masks: tubes 7:6 show hours, 5:4 show minutes
  localparam logic [7:0] HOUR_BLANK = 8'hC0;
  localparam logic [7:0] MIN_BLANK  = 8'h30;

endpackage

// File: rtl/time_set_controller_if.sv
// Button/live-time inputs and edit/alarm/display outputs of the setting controller.
// slave = the controller itself; master = the button, counter and display side.
interface time_set_controller_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       btn_mode;
  logic       btn_dec;
  logic       btn_inc;
  logic [3:0] hour_ten;
  logic [3:0] hour_one;
  logic [3:0] minute_ten;
  logic [3:0] minute_one;

  logic       time_load;
  logic [3:0] edit_hour_tens;
  logic [3:0] edit_hour_ones;
  logic [3:0] edit_min_tens;
  logic [3:0] edit_min_ones;
  logic [3:0] alarm_hour_tens;
  logic [3:0] alarm_hour_ones;
  logic [3:0] alarm_min_tens;
  logic [3:0] alarm_min_ones;
  logic       alarm_en;
  logic       show_mode;
  logic       is_setting_time;
  logic       is_setting_alarm;
  logic [7:0] digit_blank;

  modport slave (
    input  tick_1hz, tick_2hz, btn_mode, btn_dec, btn_inc,
           hour_ten, hour_one, minute_ten, minute_one,
    output time_load, edit_hour_tens, edit_hour_ones, edit_min_tens, edit_min_ones,
           alarm_hour_tens, alarm_hour_ones, alarm_min_tens, alarm_min_ones,
           alarm_en, show_mode, is_setting_time, is_setting_alarm, digit_blank
  );

  modport master (
    output tick_1hz, tick_2hz, btn_mode, btn_dec, btn_inc,
           hour_ten, hour_one, minute_ten, minute_one,
    input  time_load, edit_hour_tens, edit_hour_ones, edit_min_tens, edit_min_ones,
           alarm_hour_tens, alarm_hour_ones, alarm_min_tens, alarm_min_ones,
           alarm_en, show_mode, is_setting_time, is_setting_alarm, digit_blank
  );
endinterface

// File: rtl/bcd2_step.sv
// Combinational +/-1 on a two-digit BCD field that wraps between 00 and MAX.
// Digit-wise carry/borrow keeps every result a legal BCD value.
module bcd2_step #(
  parameter int MAX = 59
) (
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       up,
  output logic [3:0] tens_n,
  output logic [3:0] ones_n
);
  localparam logic [3:0] MAX_T = 4'(MAX / 10);
  localparam logic [3:0] MAX_O = 4'(MAX % 10);

  // NOTE: every output gets a default first so no path through the ifs infers a latch.
  always_comb begin
    tens_n = tens;
    ones_n = ones;
    if (up) begin
      if (tens == MAX_T && ones == MAX_O) begin
        tens_n = 4'd0;
        ones_n = 4'd0;
      end else if (ones == 4'd9) begin
        tens_n = tens + 4'd1;
        ones_n = 4'd0;
      end else begin
        ones_n = ones + 4'd1;
      end
    end else begin
      if (tens == 4'd0 && ones == 4'd0) begin
        tens_n = MAX_T;
        ones_n = MAX_O;
      end else if (ones == 4'd0) begin
        tens_n = tens - 4'd1;
        ones_n = 4'd9;
      end else begin
        ones_n = ones - 4'd1;
      end
    end
  end
endmodule

// File: rtl/time_set_controller.sv
// Button-driven time/alarm setting sequencer: owns the edit buffer, alarm registers,
// commit strobe to the time counters and blink/mode controls for the scan display.
module time_set_controller
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S   = 10,
  parameter int ALARM_RST_H = 7,
  parameter int ALARM_RST_M = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  time_set_controller_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [3:0] AL_HT = 4'(ALARM_RST_H / 10);
  localparam logic [3:0] AL_HO = 4'(ALARM_RST_H % 10);
  localparam logic [3:0] AL_MT = 4'(ALARM_RST_M / 10);
  localparam logic [3:0] AL_MO = 4'(ALARM_RST_M % 10);

  state_e          state_q, state_d;
  logic [TW-1:0]   tcnt_q;
  logic            phase_q, phase_d;
  logic            any_btn, setting, timeout_hit, step_en, step_up, hour_field;
  logic            time_load_q, alarm_en_q, show_mode_q, set_time_q, set_alarm_q;
  logic [7:0]      blank_q;
  logic [3:0]      e_ht, e_ho, e_mt, e_mo;
  logic [3:0]      a_ht, a_ho, a_mt, a_mo;
  logic [3:0]      hr_t_n, hr_o_n, mn_t_n, mn_o_n;

  bcd2_step #(.MAX(HOUR_MAX)) u_hour_step (
    .tens(e_ht), .ones(e_ho), .up(step_up), .tens_n(hr_t_n), .ones_n(hr_o_n)
  );
  bcd2_step #(.MAX(MIN_MAX)) u_min_step (
    .tens(e_mt), .ones(e_mo), .up(step_up), .tens_n(mn_t_n), .ones_n(mn_o_n)
  );

  always_comb begin
    any_btn     = bus.btn_mode | bus.btn_dec | bus.btn_inc;
    setting     = (state_q != NORMAL);
    hour_field  = (state_q == T_HOUR) || (state_q == A_HOUR);
    // A button in the same cycle as the final tick keeps the edit alive.
    timeout_hit = setting && bus.tick_1hz && !any_btn && (tcnt_q == TW'(TIMEOUT_S - 1));
    // The cycle after the time commit is spent loading the alarm into the buffer.
    step_en     = setting && !bus.btn_mode && (bus.btn_dec | bus.btn_inc) && !time_load_q;
    step_up     = !bus.btn_dec;

    state_d = state_q;
    if (bus.btn_mode) begin
      unique case (state_q)
        NORMAL:  state_d = T_HOUR;
        T_HOUR:  state_d = T_MIN;
        T_MIN:   state_d = A_HOUR;
        A_HOUR:  state_d = A_MIN;
        default: state_d = NORMAL;
      endcase
    end else if (timeout_hit) begin
      state_d = NORMAL;
    end

    phase_d = phase_q;
    if (state_d == NORMAL || any_btn) phase_d = 1'b0;
    else if (bus.tick_2hz)            phase_d = ~phase_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= NORMAL;
      tcnt_q      <= '0;
      phase_q     <= 1'b0;
      time_load_q <= 1'b0;
      {e_ht, e_ho, e_mt, e_mo} <= '0;
      {a_ht, a_ho, a_mt, a_mo} <= {AL_HT, AL_HO, AL_MT, AL_MO};
      alarm_en_q  <= 1'b0;
      show_mode_q <= 1'b0;
      set_time_q  <= 1'b0;
      set_alarm_q <= 1'b0;
      blank_q     <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      time_load_q <= (state_q == T_MIN) && bus.btn_mode;

      if (state_d == NORMAL || any_btn || timeout_hit) tcnt_q <= '0;
      else if (bus.tick_1hz)                           tcnt_q <= tcnt_q + TW'(1);

      if (state_q == NORMAL && bus.btn_mode)
        {e_ht, e_ho, e_mt, e_mo} <= {bus.hour_ten, bus.hour_one, bus.minute_ten, bus.minute_one};
      else if (time_load_q)
        {e_ht, e_ho, e_mt, e_mo} <= {a_ht, a_ho, a_mt, a_mo};
      else if (step_en && hour_field)
        {e_ht, e_ho} <= {hr_t_n, hr_o_n};
      else if (step_en)
        {e_mt, e_mo} <= {mn_t_n, mn_o_n};

      if (state_q == A_MIN && bus.btn_mode)
        {a_ht, a_ho, a_mt, a_mo} <= {e_ht, e_ho, e_mt, e_mo};

      if (state_q == NORMAL && !bus.btn_mode) begin
        if (bus.btn_dec)      show_mode_q <= ~show_mode_q;
        else if (bus.btn_inc) alarm_en_q  <= ~alarm_en_q;
      end

      set_time_q  <= (state_d == T_HOUR) || (state_d == T_MIN);
      set_alarm_q <= (state_d == A_HOUR) || (state_d == A_MIN);
      if (!phase_d || state_d == NORMAL)                 blank_q <= '0;
      else if (state_d == T_HOUR || state_d == A_HOUR)   blank_q <= HOUR_BLANK;
      else                                               blank_q <= MIN_BLANK;
    end
  end

  assign bus.time_load        = time_load_q;
  assign bus.edit_hour_tens   = e_ht;
  assign bus.edit_hour_ones   = e_ho;
  assign bus.edit_min_tens    = e_mt;
  assign bus.edit_min_ones    = e_mo;
  assign bus.alarm_hour_tens  = a_ht;
  assign bus.alarm_hour_ones  = a_ho;
  assign bus.alarm_min_tens   = a_mt;
  assign bus.alarm_min_ones   = a_mo;
  assign bus.alarm_en         = alarm_en_q;
  assign bus.show_mode        = show_mode_q;
  assign bus.is_setting_time  = set_time_q;
  assign bus.is_setting_alarm = set_alarm_q;
  assign bus.digit_blank      = blank_q;
endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller: hand-computed BCD edit/alarm values,
// commit strobe count, timeout, button priority and blink masks.
module tb_time_set_controller;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   nvec  = 0;
  int   nerr  = 0;
  int   tl_count = 0;

  time_set_controller_if bus();

  time_set_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Count commit strobes just after each edge.
  always @(posedge clk) begin
    #2;
    if (bus.time_load === 1'b1) tl_count++;
  end

  wire [15:0] edit_v  = {bus.edit_hour_tens, bus.edit_hour_ones, bus.edit_min_tens, bus.edit_min_ones};
  wire [15:0] alarm_v = {bus.alarm_hour_tens, bus.alarm_hour_ones, bus.alarm_min_tens, bus.alarm_min_ones};

  task automatic cyc(input logic m, input logic d, input logic i, input logic t1, input logic t2);
    @(negedge clk);
    bus.btn_mode = m; bus.btn_dec = d; bus.btn_inc = i; bus.tick_1hz = t1; bus.tick_2hz = t2;
    @(negedge clk);
    bus.btn_mode = 0; bus.btn_dec = 0; bus.btn_inc = 0; bus.tick_1hz = 0; bus.tick_2hz = 0;
  endtask

  task automatic set_live(input logic [15:0] t);
    {bus.hour_ten, bus.hour_one, bus.minute_ten, bus.minute_one} = t;
  endtask

  task automatic test_reset;
    bus.btn_mode = 0; bus.btn_dec = 0; bus.btn_inc = 0; bus.tick_1hz = 0; bus.tick_2hz = 0;
    set_live(16'h1345);
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    nvec++; if (alarm_v !== 16'h0700) begin nerr++; $display("FAIL reset_alarm got %h want 0700", alarm_v); end
    nvec++; if (edit_v !== 16'h0000) begin nerr++; $display("FAIL reset_edit got %h want 0000", edit_v); end
    nvec++; if ({bus.show_mode, bus.alarm_en} !== 2'b00) begin nerr++; $display("FAIL reset_modes got %b want 00", {bus.show_mode, bus.alarm_en}); end
    nvec++; if (bus.digit_blank !== 8'h00) begin nerr++; $display("FAIL reset_blank got %h want 00", bus.digit_blank); end
    nvec++; if ({bus.is_setting_time, bus.is_setting_alarm} !== 2'b00) begin nerr++; $display("FAIL reset_flags got %b want 00", {bus.is_setting_time, bus.is_setting_alarm}); end
    nvec++; if (tl_count !== 0) begin nerr++; $display("FAIL reset_time_load got %0d want 0", tl_count); end
  endtask

  task automatic test_time_set;
    set_live(16'h1345);
    cyc(1, 0, 0, 0, 0);
    nvec++; if (edit_v !== 16'h1345 || bus.is_setting_time !== 1'b1) begin nerr++; $display("FAIL snapshot got %h/%b want 1345/1", edit_v, bus.is_setting_time); end
    repeat (11) cyc(0, 0, 1, 0, 0);
    nvec++; if (edit_v !== 16'h0045) begin nerr++; $display("FAIL hour_wrap_up got %h want 0045", edit_v); end
    cyc(1, 0, 0, 0, 0);
    repeat (46) cyc(0, 1, 0, 0, 0);
    nvec++; if (edit_v !== 16'h0059) begin nerr++; $display("FAIL min_wrap_dn got %h want 0059", edit_v); end
    nvec++; if (tl_count !== 0) begin nerr++; $display("FAIL early_load got %0d want 0", tl_count); end
    cyc(1, 0, 0, 0, 0);
    nvec++; if (bus.time_load !== 1'b1 || edit_v !== 16'h0059) begin nerr++; $display("FAIL commit got %b/%h want 1/0059", bus.time_load, edit_v); end
    @(negedge clk);
    nvec++; if (bus.time_load !== 1'b0 || tl_count !== 1) begin nerr++; $display("FAIL commit_once got %b/%0d want 0/1", bus.time_load, tl_count); end
    nvec++; if (edit_v !== 16'h0700 || bus.is_setting_alarm !== 1'b1 || bus.is_setting_time !== 1'b0) begin
      nerr++; $display("FAIL alarm_load got %h/%b%b want 0700/10", edit_v, bus.is_setting_alarm, bus.is_setting_time); end
  endtask

  task automatic test_alarm_set;
    cyc(0, 0, 1, 0, 0);
    nvec++; if (edit_v !== 16'h0800) begin nerr++; $display("FAIL alarm_hour_inc got %h want 0800", edit_v); end
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    nvec++; if (edit_v !== 16'h0859) begin nerr++; $display("FAIL alarm_min_dn got %h want 0859", edit_v); end
    cyc(0, 0, 1, 0, 0);
    nvec++; if (edit_v !== 16'h0800) begin nerr++; $display("FAIL alarm_min_up got %h want 0800", edit_v); end
    nvec++; if (alarm_v !== 16'h0700) begin nerr++; $display("FAIL alarm_early got %h want 0700", alarm_v); end
    cyc(1, 0, 0, 0, 0);
    nvec++; if (alarm_v !== 16'h0800 || bus.is_setting_alarm !== 1'b0) begin nerr++; $display("FAIL alarm_commit got %h/%b want 0800/0", alarm_v, bus.is_setting_alarm); end
    nvec++; if (tl_count !== 1) begin nerr++; $display("FAIL alarm_no_load got %0d want 1", tl_count); end
  endtask

  task automatic test_timeout;
    set_live(16'h1030);
    cyc(1, 0, 0, 0, 0);
    repeat (9) cyc(0, 0, 0, 1, 0);
    nvec++; if (bus.is_setting_time !== 1'b1) begin nerr++; $display("FAIL timeout_early got %b want 1", bus.is_setting_time); end
    cyc(0, 0, 0, 1, 0);
    nvec++; if (bus.is_setting_time !== 1'b0 || tl_count !== 1 || alarm_v !== 16'h0800) begin
      nerr++; $display("FAIL timeout got %b/%0d/%h want 0/1/0800", bus.is_setting_time, tl_count, alarm_v); end
    cyc(1, 0, 0, 0, 0);
    repeat (9) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    nvec++; if (bus.is_setting_time !== 1'b1 || edit_v !== 16'h1130) begin nerr++; $display("FAIL timeout_btn got %b/%h want 1/1130", bus.is_setting_time, edit_v); end
    repeat (9) cyc(0, 0, 0, 1, 0);
    nvec++; if (bus.is_setting_time !== 1'b1) begin nerr++; $display("FAIL timeout_cleared got %b want 1", bus.is_setting_time); end
    cyc(0, 0, 0, 1, 0);
    nvec++; if (bus.is_setting_time !== 1'b0 || tl_count !== 1) begin nerr++; $display("FAIL timeout2 got %b/%0d want 0/1", bus.is_setting_time, tl_count); end
  endtask

  task automatic test_priority;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    nvec++; if (edit_v !== 16'h1030 || bus.is_setting_time !== 1'b1) begin nerr++; $display("FAIL mode_over_inc got %h/%b want 1030/1", edit_v, bus.is_setting_time); end
    cyc(0, 0, 0, 0, 1);
    nvec++; if (bus.digit_blank !== 8'h30) begin nerr++; $display("FAIL min_blank got %h want 30", bus.digit_blank); end
    repeat (10) cyc(0, 0, 0, 1, 0);
    nvec++; if (bus.is_setting_time !== 1'b0 || bus.digit_blank !== 8'h00) begin nerr++; $display("FAIL prio_exit got %b/%h want 0/00", bus.is_setting_time, bus.digit_blank); end
    cyc(0, 1, 1, 0, 0);
    nvec++; if ({bus.show_mode, bus.alarm_en} !== 2'b10) begin nerr++; $display("FAIL dec_over_inc got %b want 10", {bus.show_mode, bus.alarm_en}); end
    cyc(0, 0, 1, 0, 0);
    nvec++; if ({bus.show_mode, bus.alarm_en} !== 2'b11) begin nerr++; $display("FAIL alarm_toggle got %b want 11", {bus.show_mode, bus.alarm_en}); end
  endtask

  task automatic test_blink;
    logic [7:0] exp_blank [4] = '{8'hC0, 8'h00, 8'hC0, 8'h00};
    cyc(1, 0, 0, 0, 0);
    nvec++; if (bus.digit_blank !== 8'h00) begin nerr++; $display("FAIL blink_entry got %h want 00", bus.digit_blank); end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 1);
      nvec++; if (bus.digit_blank !== exp_blank[k]) begin nerr++; $display("FAIL blink_%0d got %h want %h", k, bus.digit_blank, exp_blank[k]); end
    end
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);
    nvec++; if (bus.digit_blank !== 8'h00) begin nerr++; $display("FAIL blink_btn got %h want 00", bus.digit_blank); end
  endtask

  task automatic test_reset_mid_edit;
    cyc(0, 0, 1, 0, 0);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    nvec++; if (bus.is_setting_time !== 1'b0 || edit_v !== 16'h0000 || alarm_v !== 16'h0700 || bus.alarm_en !== 1'b0) begin
      nerr++; $display("FAIL mid_reset got %b/%h/%h/%b want 0/0000/0700/0", bus.is_setting_time, edit_v, alarm_v, bus.alarm_en); end
    nvec++; if (tl_count !== 1) begin nerr++; $display("FAIL mid_reset_load got %0d want 1", tl_count); end
  endtask

  initial begin
    test_reset;
    test_time_set;
    test_alarm_set;
    test_timeout;
    test_priority;
    test_blink;
    test_reset_mid_edit;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
